stream_mux_2to1: RTL and testbench

Two-input, one-output packet stream multiplexer: the merge-side counterpart of the 1-to-2 demux. Each input carries valid/ready beats with a `last` marker. The block arbitrates round-robin between inputs at packet boundaries and registers the selected beat into a single output stage. It sits wherever two producer streams share one consumer, and records which source each beat came from.

---
 rtl/stream_mux_2to1_pkg.sv | 14 +
 rtl/stream_mux_2to1_rr_arbiter_2.sv | 60 ++++++
 rtl/stream_mux_2to1.sv | 100 ++++++++++
 tb/tb_stream_mux_2to1.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_2to1_pkg.sv
// Shared definitions for the two-input packet stream multiplexer.
//   state_t        : arbiter lock state (idle, locked to in0, locked to in1)
//   DATA_W_DEFAULT : default payload width
package stream_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BUSY0 = 2'b01,
    ST_BUSY1 = 2'b10
  } state_t;

  localparam int unsigned DATA_W_DEFAULT = 8;

endpackage

// File: rtl/stream_mux_2to1_rr_arbiter_2.sv
// Packet-granular round-robin arbiter for two sources.
//   clk, rst_n     : clock, asynchronous active-low reset
//   valid0/valid1  : source beat-present flags
//   load           : the granted beat is loaded into the output stage
//   done           : the loaded beat ends its packet (load && last)
//   g              : granted source index
// Once a packet's first beat is loaded the grant locks to that source until
// its last beat is loaded; the preference bit then flips to the other source.
import stream_mux_pkg::*;

module rr_arbiter_2 (
  input  logic clk,
  input  logic rst_n,
  input  logic valid0,
  input  logic valid1,
  input  logic load,
  input  logic done,
  output logic g
);

  state_t state_q, state_d;
  logic   prio_q, prio_d;

  always_comb begin
    g = prio_q;
    unique case (state_q)
      ST_BUSY0: g = 1'b0;
      ST_BUSY1: g = 1'b1;
      default: begin
        // Exactly one requester wins outright; otherwise the preferred one.
        if (valid0 ^ valid1) g = valid1;
        else                 g = prio_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    if (load) begin
      if (done) begin
        state_d = ST_IDLE;
        prio_d  = ~g;
      end else begin
        state_d = g ? ST_BUSY1 : ST_BUSY0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

endmodule

// File: rtl/stream_mux_2to1.sv
// Two-input, one-output packet stream multiplexer with a single registered
// output stage. Arbitration is round-robin at packet boundaries; packets are
// never interleaved.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   in0_* / in1_*               : source streams (valid/ready/data/last)
//   out_valid/out_ready         : output handshake
//   out_data/out_last/out_sel   : registered payload, last marker, source index
import stream_mux_pkg::*;

module stream_mux_2to1 #(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in0_valid,
  output logic              in0_ready,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_last,
  input  logic              in1_valid,
  output logic              in1_ready,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_sel
);

  logic              g;
  logic              can_load;
  logic              load;
  logic              done;
  logic              sel_valid;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              out_last_q,  out_last_d;
  logic              out_sel_q,   out_sel_d;

  rr_arbiter_2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid0 (in0_valid),
    .valid1 (in1_valid),
    .load   (load),
    .done   (done),
    .g      (g)
  );

  always_comb begin
    // The stage may refill in the same cycle it drains.
    can_load  = !out_valid_q || out_ready;
    sel_valid = g ? in1_valid : in0_valid;
    sel_last  = g ? in1_last  : in0_last;
    sel_data  = g ? in1_data  : in0_data;
    load      = can_load && sel_valid;
    done      = load && sel_last;
    // rst_n gating keeps both sources stalled while reset is held.
    in0_ready = rst_n && can_load && !g;
    in1_ready = rst_n && can_load &&  g;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_last_d  = sel_last;
      out_sel_d   = g;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux_2to1.sv
module tb_stream_mux_2to1;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in0_valid, in1_valid, in0_last, in1_last, out_ready;
  logic [DW-1:0] in0_data, in1_data;
  logic          in0_ready, in1_ready, out_valid, out_last, out_sel;
  logic [DW-1:0] out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_mux_2to1 #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in0_data  (in0_data),
    .in0_last  (in0_last),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .in1_data  (in1_data),
    .in1_last  (in1_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel)
  );

  // Reference model: which source owns the output (-1 = nobody), who is
  // preferred next, and the contents of the one-entry output stage.
  int            m_owner;
  bit            m_prio, m_ov, m_ol, m_os;
  logic [DW-1:0] m_od;

  // Pre-edge samples and model expectations for the current cycle.
  logic          s_r0, s_r1, e_r0, e_r1, s_ov;

  // Source packet queues {last, data} and delivered beats {sel, last, data}.
  logic [DW:0]   q0[$], q1[$];
  logic [DW+1:0] dlv[$];

  function automatic int grant();
    if (m_owner >= 0)            return m_owner;
    if (in0_valid && !in1_valid) return 0;
    if (in1_valid && !in0_valid) return 1;
    return int'(m_prio);
  endfunction

  task automatic model_reset();
    m_owner = -1; m_prio = 0; m_ov = 0; m_ol = 0; m_os = 0; m_od = '0;
  endtask

  task automatic cycle();
    int g;
    bit can;
    @(negedge clk);
    s_r0 = in0_ready; s_r1 = in1_ready; s_ov = out_valid;
    g   = grant();
    can = !m_ov || out_ready;
    e_r0 = rst_n && can && (g == 0);
    e_r1 = rst_n && can && (g == 1);
    if (s_ov && out_ready && rst_n) dlv.push_back({out_sel, out_last, out_data});
    @(posedge clk);
    if (rst_n) begin
      if (can && ((g == 0) ? in0_valid : in1_valid)) begin
        m_ov = 1;
        m_od = (g == 0) ? in0_data : in1_data;
        m_ol = (g == 0) ? in0_last : in1_last;
        m_os = (g == 1);
        if (m_ol) begin m_owner = -1; m_prio = (g == 0); end
        else m_owner = g;
      end else if (out_ready) begin
        m_ov = 0;
      end
    end
    #1;
  endtask

  task automatic run_cycle(input bit en0, input bit en1);
    in0_valid = en0 && (q0.size() > 0);
    in1_valid = en1 && (q1.size() > 0);
    if (q0.size() > 0) {in0_last, in0_data} = q0[0];
    else begin in0_last = $urandom_range(1); in0_data = DW'($urandom); end
    if (q1.size() > 0) {in1_last, in1_data} = q1[0];
    else begin in1_last = $urandom_range(1); in1_data = DW'($urandom); end
    cycle();
    if (e_r0 && in0_valid) void'(q0.pop_front());
    if (e_r1 && in1_valid) void'(q1.pop_front());
  endtask

  task automatic drain();
    out_ready = 1;
    for (int i = 0; i < 3; i++) run_cycle(0, 0);
    dlv.delete();
  endtask

  task automatic test_reset();
    rst_n = 0; in0_valid = 1; in1_valid = 1; out_ready = 0;
    in0_data = 8'hAA; in1_data = 8'h55; in0_last = 0; in1_last = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, out_data, out_last, out_sel} !== {1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_out: got v=%b d=%h l=%b s=%b want all 0", out_valid, out_data, out_last, out_sel);
    end
    checks++;
    if ({in0_ready, in1_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready: got %b%b want 00", in0_ready, in1_ready);
    end
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    checks++;
    if ({in0_ready, in1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL release_ready: got %b%b want 10", in0_ready, in1_ready);
    end
    in0_valid = 0; in1_valid = 0;
    #1;
  endtask

  task automatic test_contention();
    logic [DW-1:0] exp_d [6] = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};
    logic          exp_s [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [DW:0]   seen[$];
    int first = -1, lastc = -1;
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      q0.push_back({(i == 2), 8'h10 + DW'(i)});
      q1.push_back({(i == 2), 8'h20 + DW'(i)});
    end
    for (int c = 0; c < 8; c++) begin
      run_cycle(1, 1);
      if (out_valid) begin
        seen.push_back({out_sel, out_data});
        if (first < 0) first = c;
        lastc = c;
      end
    end
    checks++;
    if (seen.size() != 6 || lastc - first != 5) begin
      errors++;
      $display("FAIL contention_count: got %0d beats over %0d cycles want 6 over 6", seen.size(), lastc - first + 1);
    end
    for (int i = 0; i < 6 && i < seen.size(); i++) begin
      checks++;
      if (seen[i] !== {exp_s[i], exp_d[i]}) begin
        errors++;
        $display("FAIL contention_beat%0d: got sel/data %h want %h", i, seen[i], {exp_s[i], exp_d[i]});
      end
    end
    drain();
  endtask

  task automatic test_lock();
    int n0 = 0, sel0_out = 0;
    out_ready = 1;
    for (int i = 0; i < 3; i++) q0.push_back({(i == 2), 8'h30 + DW'(i)});
    for (int c = 0; c < 10; c++) begin
      int n0_before = n0;
      run_cycle(1, 1);
      if (e_r0 && in0_valid) n0++;
      if (c == 0) for (int i = 0; i < 3; i++) q1.push_back({(i == 2), 8'hC0 + DW'(i)});
      if (n0_before >= 1 && n0_before < 3) begin
        checks++;
        if (s_r1 !== 1'b0) begin
          errors++;
          $display("FAIL lock_in1_ready: cycle %0d got %b want 0", c, s_r1);
        end
      end
      if (out_valid && !out_sel) sel0_out++;
      if (out_valid && out_sel) begin
        checks++;
        if (sel0_out != 3) begin
          errors++;
          $display("FAIL lock_interleave: in1 beat %h after %0d in0 beats want 3", out_data, sel0_out);
        end
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [DW+1:0] snap;
    logic [DW+1:0] exp_b [5] = '{{2'b00, 8'h40}, {2'b00, 8'h41}, {2'b01, 8'h42},
                                 {2'b10, 8'h50}, {2'b11, 8'h51}};
    out_ready = 1;
    for (int i = 0; i < 3; i++) q0.push_back({(i == 2), 8'h40 + DW'(i)});
    for (int i = 0; i < 2; i++) q1.push_back({(i == 1), 8'h50 + DW'(i)});
    run_cycle(1, 1);
    run_cycle(1, 1);
    snap = {out_sel, out_last, out_data};
    out_ready = 0;
    for (int c = 0; c < 4; c++) begin
      run_cycle(1, 1);
      checks++;
      if ({out_valid, out_sel, out_last, out_data} !== {1'b1, snap}) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d got v=%b %h want v=1 %h", c, out_valid, {out_sel, out_last, out_data}, snap);
      end
      checks++;
      if ({s_r0, s_r1} !== 2'b00) begin
        errors++;
        $display("FAIL bp_ready: cycle %0d got %b%b want 00", c, s_r0, s_r1);
      end
    end
    out_ready = 1;
    for (int c = 0; c < 6; c++) run_cycle(1, 1);
    checks++;
    if (dlv.size() != 5) begin
      errors++;
      $display("FAIL bp_count: got %0d delivered want 5", dlv.size());
    end
    for (int i = 0; i < 5 && i < dlv.size(); i++) begin
      checks++;
      if (dlv[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL bp_beat%0d: got %h want %h", i, dlv[i], exp_b[i]);
      end
    end
    drain();
  endtask

  task automatic test_single_beat();
    logic prev;
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      q0.push_back({1'b1, DW'($urandom)});
      q1.push_back({1'b1, DW'($urandom)});
    end
    for (int c = 0; c < 12; c++) begin
      run_cycle(1, 1);
      checks++;
      if (out_valid !== 1'b1 || out_sel !== ((c % 2) == 1)) begin
        errors++;
        $display("FAIL single_alt: cycle %0d got v=%b sel=%b want v=1 sel=%0d", c, out_valid, out_sel, c % 2);
      end
      prev = out_sel;
    end
    drain();
  endtask

  task automatic test_mid_reset();
    out_ready = 1;
    for (int i = 0; i < 3; i++) q1.push_back({(i == 2), 8'h60 + DW'(i)});
    run_cycle(0, 1);
    run_cycle(0, 1);
    #2 rst_n = 0;
    #1;
    checks++;
    if ({out_valid, out_data, in0_ready, in1_ready} !== {1'b0, 8'h00, 2'b00}) begin
      errors++;
      $display("FAIL midrst_out: got v=%b d=%h r=%b%b want v=0 d=00 r=00", out_valid, out_data, in0_ready, in1_ready);
    end
    model_reset();
    q1.delete();
    @(posedge clk); #1 rst_n = 1;
    q0.push_back({1'b0, 8'h70}); q0.push_back({1'b1, 8'h71});
    q1.push_back({1'b1, 8'h80});
    run_cycle(1, 1);
    checks++;
    if ({s_r0, s_r1, out_valid, out_sel, out_data} !== {2'b10, 1'b1, 1'b0, 8'h70}) begin
      errors++;
      $display("FAIL midrst_grant: got r=%b%b v=%b s=%b d=%h want r=10 v=1 s=0 d=70", s_r0, s_r1, out_valid, out_sel, out_data);
    end
    for (int c = 0; c < 4; c++) run_cycle(1, 1);
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        if ((k == 0 ? q0.size() : q1.size()) < 2) begin
          int len = $urandom_range(4, 1);
          for (int i = 0; i < len; i++) begin
            if (k == 0) q0.push_back({(i == len - 1), DW'($urandom)});
            else        q1.push_back({(i == len - 1), DW'($urandom)});
          end
        end
      end
      out_ready = ($urandom_range(3) != 0);
      run_cycle($urandom_range(4) != 0, $urandom_range(4) != 0);
      checks++;
      if ({s_r0, s_r1} !== {e_r0, e_r1}) begin
        errors++;
        $display("FAIL rand_ready: cycle %0d got %b%b want %b%b", c, s_r0, s_r1, e_r0, e_r1);
      end
      checks++;
      if ({out_valid, out_sel, out_last, out_data} !== {m_ov, m_os, m_ol, m_od}) begin
        errors++;
        $display("FAIL rand_out: cycle %0d got v=%b s=%b l=%b d=%h want v=%b s=%b l=%b d=%h",
                 c, out_valid, out_sel, out_last, out_data, m_ov, m_os, m_ol, m_od);
      end
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_lock();
    test_backpressure();
    test_single_beat();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
